// File: rtl/ag6502_bus_arbiter.sv
// 6502 bus arbiter: derives phi_0 from baseclk and shares one memory port
// between video (phi_0 low half) and CPU or DMA (phi_0 high half).
module ag6502_bus_arbiter #(
    parameter int HALF     = 5,
    parameter int AW       = 16,
    parameter int MAXBURST = 0
) (
    input  logic          baseclk,
    input  logic          rst,
    output logic          phi_0,
    input  logic [AW-1:0] cpu_ab,
    input  logic          cpu_read,
    output logic          cpu_rdy,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    input  logic          dma_we,
    output logic          dma_gnt,
    output logic          dma_done,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_strobe,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [1:0]    mem_owner
);

    typedef enum logic [1:0] {
        S_CPU  = 2'd0,
        S_WAIT = 2'd1,
        S_DMA  = 2'd2
    } state_t;

    localparam logic [1:0] OWN_CPU = 2'd0;
    localparam logic [1:0] OWN_DMA = 2'd1;
    localparam logic [1:0] OWN_VID = 2'd2;

    localparam logic [4:0] HALF_C = 5'(HALF);
    localparam logic [4:0] PRE_C  = 5'(HALF - 1);
    localparam logic [4:0] LAST_C = 5'(2 * HALF - 1);
    localparam logic [7:0] MAXB_C = 8'(MAXBURST);

    state_t        state, state_nxt;
    logic [4:0]    cnt, cnt_nxt;
    logic [7:0]    burst, burst_nxt;
    logic          boundary, at_high;

    logic          phi_nxt, rdy_nxt, gnt_nxt, done_nxt, vs_nxt, we_nxt;
    logic          high_dma, high_stall;
    logic [1:0]    owner_nxt;
    logic [AW-1:0] addr_nxt;

    // Every output is computed from the tick the counter is about to enter,
    // so the registered value lines up with that tick.
    assign boundary = (cnt == LAST_C);
    assign at_high  = (cnt == PRE_C);
    assign cnt_nxt  = boundary ? 5'd0 : cnt + 5'd1;

    always_ff @(posedge baseclk or negedge rst) begin
        if (!rst) begin
            state      <= S_CPU;
            cnt        <= 5'd0;
            burst      <= 8'd0;
            phi_0      <= 1'b0;
            cpu_rdy    <= 1'b1;
            dma_gnt    <= 1'b0;
            dma_done   <= 1'b0;
            vid_strobe <= 1'b0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_owner  <= OWN_VID;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            burst      <= burst_nxt;
            phi_0      <= phi_nxt;
            cpu_rdy    <= rdy_nxt;
            dma_gnt    <= gnt_nxt;
            dma_done   <= done_nxt;
            vid_strobe <= vs_nxt;
            mem_addr   <= addr_nxt;
            mem_we     <= we_nxt;
            mem_owner  <= owner_nxt;
        end
    end

    // The WAIT->DMA move happens mid-cycle, when the CPU is seen stalled on a read.
    always_comb begin
        state_nxt = state;
        burst_nxt = burst;
        case (state)
            S_CPU: begin
                if (boundary && dma_req)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (at_high && cpu_read && dma_req) begin
                    state_nxt = S_DMA;
                    burst_nxt = 8'd1;
                end else if (boundary && !dma_req) begin
                    state_nxt = S_CPU;
                end
            end
            S_DMA: begin
                if (at_high && dma_req)
                    burst_nxt = burst + 8'd1;
                if (boundary && (!dma_req || ((MAXBURST != 0) && (burst == MAXB_C)))) begin
                    state_nxt = S_CPU;
                    burst_nxt = 8'd0;
                end
            end
            default: begin
                state_nxt = S_CPU;
                burst_nxt = 8'd0;
            end
        endcase
    end

    always_comb begin
        high_dma   = ((state == S_WAIT) && cpu_read && dma_req) ||
                     ((state == S_DMA) && dma_req);
        high_stall = ((state == S_WAIT) && cpu_read && !dma_req) ||
                     ((state == S_DMA) && !dma_req);

        phi_nxt   = (cnt_nxt >= HALF_C);
        rdy_nxt   = (state_nxt == S_CPU);
        vs_nxt    = (cnt_nxt == PRE_C);
        done_nxt  = (cnt_nxt == LAST_C) && (mem_owner == OWN_DMA);
        owner_nxt = mem_owner;
        addr_nxt  = mem_addr;
        we_nxt    = mem_we;
        gnt_nxt   = dma_gnt;

        if (boundary) begin
            owner_nxt = OWN_VID;
            addr_nxt  = vid_addr;
            we_nxt    = 1'b0;
            gnt_nxt   = 1'b0;
        end else if (at_high) begin
            if (high_dma) begin
                owner_nxt = OWN_DMA;
                addr_nxt  = dma_addr;
                we_nxt    = dma_we;
                gnt_nxt   = 1'b1;
            end else begin
                owner_nxt = OWN_CPU;
                addr_nxt  = cpu_ab;
                we_nxt    = high_stall ? 1'b0 : ~cpu_read;
                gnt_nxt   = 1'b0;
            end
        end
    end

endmodule
